// File: rtl/flash_boot_blinker_pkg.sv
// Shared types and constants for the flash-booted LED blinker.
// Holds the boot FSM state encoding, the SPI READ opcode and the pad-map
// positions of the LED field inside the 38-bit user I/O bus.
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam logic [7:0] SPI_READ_CMD = 8'h03;
  localparam int         CFG_BITS     = 32;
  localparam int         LED_LSB      = 2;
  localparam int         LED_MSB      = 9;
  localparam int         PAD_W        = 38;

endpackage

// File: rtl/flash_boot_blinker_spi_read_master.sv
// spi_read_master: one-shot SPI mode-0 transaction of BITS command bits out
// followed by BITS data bits in, both MSB first.
// Ports: i_clk/i_rst (sync, active-high), i_start (level, sampled while idle),
//  i_tx_bits (command word), i_miso; o_csb/o_sclk/o_mosi to the flash,
//  o_rx_data (last BITS sampled bits), o_rx_phase (command phase finished),
//  o_done (one-cycle pulse when csb returns high).
module spi_read_master #(
  parameter int SPI_DIV = 2,
  parameter int BITS    = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [BITS-1:0] i_tx_bits,
  input  logic            i_miso,
  output logic            o_csb,
  output logic            o_sclk,
  output logic            o_mosi,
  output logic [BITS-1:0] o_rx_data,
  output logic            o_rx_phase,
  output logic            o_done
);

  localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int CNT_W = $clog2(2 * BITS + 1);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_rises;
  logic [BITS-1:0]  r_tx;
  logic [BITS-1:0]  r_rx;
  logic             r_csb;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_done;
  logic             w_tick;

  // One flash_clk half-period has elapsed.
  assign w_tick = (r_div == DIV_W'(SPI_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div   <= '0;
      r_rises <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_csb   <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_csb) begin
        if (i_start) begin
          // First bit is presented with csb so it is stable a full
          // half-period before the first rising edge.
          r_csb   <= 1'b0;
          r_sclk  <= 1'b0;
          r_mosi  <= i_tx_bits[BITS-1];
          r_tx    <= i_tx_bits << 1;
          r_div   <= '0;
          r_rises <= '0;
        end
      end else if (w_tick) begin
        r_div <= '0;
        if (!r_sclk) begin
          r_sclk  <= 1'b1;
          r_rises <= r_rises + 1'b1;
          r_rx    <= {r_rx[BITS-2:0], i_miso};
        end else if (r_rises == CNT_W'(2 * BITS)) begin
          // Finish on the falling half so sclk is already low when csb rises.
          r_sclk <= 1'b0;
          r_csb  <= 1'b1;
          r_mosi <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_sclk <= 1'b0;
          r_mosi <= r_tx[BITS-1];
          r_tx   <= r_tx << 1;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_csb      = r_csb;
  assign o_sclk     = r_sclk;
  assign o_mosi     = r_mosi;
  assign o_rx_data  = r_rx;
  assign o_rx_phase = (r_rises >= CNT_W'(BITS));
  assign o_done     = r_done;

endmodule

// File: rtl/flash_boot_blinker.sv
// flash_boot_blinker: reads a 4-byte config record from SPI NOR flash after
// reset (READ 0x03 @ 0x000000), then blinks an 8-bit pattern on mprj_io[9:2].
// Ports: clock/reset (sync, active-high); flash_csb/clk/io0 out, flash_io1 in;
//  mprj_io_out/oeb 38-bit pad ring; boot_done high in RUN.
module flash_boot_blinker
  import blink_pkg::*;
#(
  parameter int         SPI_DIV             = 2,
  parameter int         DEFAULT_HALF_PERIOD = 2000,
  parameter logic [7:0] DEFAULT_PATTERN     = 8'h01
) (
  input  logic             clock,
  input  logic             reset,
  output logic             flash_csb,
  output logic             flash_clk,
  output logic             flash_io0,
  input  logic             flash_io1,
  output logic [PAD_W-1:0] mprj_io_out,
  output logic [PAD_W-1:0] mprj_io_oeb,
  output logic             boot_done
);

  state_t              r_state;
  state_t              w_next;
  logic                w_start;
  logic                w_rx_phase;
  logic                w_done;
  logic [CFG_BITS-1:0] w_rx_data;
  logic [23:0]         w_cfg_half;
  logic [7:0]          w_cfg_pat;
  logic [23:0]         r_half;
  logic [7:0]          r_pattern;
  logic [23:0]         r_cnt;
  logic                r_phase;
  logic [7:0]          w_led;

  spi_read_master #(
    .SPI_DIV (SPI_DIV),
    .BITS    (CFG_BITS)
  ) u_spi (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_start    (w_start),
    .i_tx_bits  ({SPI_READ_CMD, 24'h000000}),
    .i_miso     (flash_io1),
    .o_csb      (flash_csb),
    .o_sclk     (flash_clk),
    .o_mosi     (flash_io0),
    .o_rx_data  (w_rx_data),
    .o_rx_phase (w_rx_phase),
    .o_done     (w_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = 1'b1;
        w_next  = CMD;
      end
      CMD:  if (w_rx_phase) w_next = DATA;
      DATA: if (w_done) w_next = RUN;
      RUN:  w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  // Erased flash falls back to defaults; a zero half-period would never
  // expire, so it is promoted to one.
  always_comb begin
    w_cfg_half = w_rx_data[31:8];
    w_cfg_pat  = w_rx_data[7:0];
    if (&w_rx_data) begin
      w_cfg_half = 24'(DEFAULT_HALF_PERIOD);
      w_cfg_pat  = DEFAULT_PATTERN;
    end else if (w_cfg_half == 24'd0) begin
      w_cfg_half = 24'd1;
    end
  end

  // Counter reloads on the same edge it expires, so every LED transition
  // is exactly r_half cycles after the previous one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_half    <= 24'd0;
      r_pattern <= 8'h00;
      r_cnt     <= 24'd0;
      r_phase   <= 1'b0;
    end else if ((r_state == DATA) && w_done) begin
      r_half    <= w_cfg_half;
      r_pattern <= w_cfg_pat;
      r_cnt     <= w_cfg_half;
      r_phase   <= 1'b0;
    end else if (r_state == RUN) begin
      if (r_cnt == 24'd1) begin
        r_cnt   <= r_half;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt - 24'd1;
      end
    end
  end

  assign w_led     = r_phase ? r_pattern : 8'h00;
  assign boot_done = (r_state == RUN);

  always_comb begin
    mprj_io_out                  = '0;
    mprj_io_out[LED_MSB:LED_LSB] = w_led;
    mprj_io_oeb                  = '1;
    mprj_io_oeb[LED_MSB:LED_LSB] = '0;
  end

endmodule

// File: tb/tb_flash_boot_blinker.sv
// Bench for flash_boot_blinker: a behavioural SPI flash, a blink-timing model
// derived from the config word, and directed boot scenarios.
module tb_flash_boot_blinker;

  localparam int SPI_DIV  = 2;
  localparam int BOOT_MAX = 64 * 2 * SPI_DIV + 4;
  localparam logic [37:0] OEB_EXP  = 38'h3F_FFFF_FC03;
  localparam logic [37:0] LED_MASK = 38'h00_0000_03FC;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flash_csb;
  logic        flash_clk;
  logic        flash_io0;
  logic        flash_io1 = 1'b0;
  logic [37:0] mprj_io_out;
  logic [37:0] mprj_io_oeb;
  logic        boot_done;

  flash_boot_blinker #(
    .SPI_DIV             (SPI_DIV),
    .DEFAULT_HALF_PERIOD (2000),
    .DEFAULT_PATTERN     (8'h01)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flash_csb   (flash_csb),
    .flash_clk   (flash_clk),
    .flash_io0   (flash_io0),
    .flash_io1   (flash_io1),
    .mprj_io_out (mprj_io_out),
    .mprj_io_oeb (mprj_io_oeb),
    .boot_done   (boot_done)
  );

  always #50 clock = ~clock;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge clock) begin
    cyc         <= cyc + 1;
    rst_at_edge <= reset;
  end

  // Flash model: counts SCK rises per select, captures the command bits,
  // and shifts the stored word out on falling edges after the command.
  logic [31:0] flash_word = 32'h0;
  int          sck_rises  = 0;
  logic [31:0] cmd_seen   = 32'h0;

  always @(posedge flash_clk or negedge flash_csb) begin
    if (!flash_clk) begin
      sck_rises = 0;
      cmd_seen  = 32'h0;
    end else if (!flash_csb) begin
      if (sck_rises < 32) cmd_seen = {cmd_seen[30:0], flash_io0};
      sck_rises = sck_rises + 1;
    end
  end

  always @(negedge flash_clk) begin
    if (!flash_csb && sck_rises >= 32 && sck_rises < 64)
      flash_io1 = flash_word[63 - sck_rises];
  end

  int          n_vec = 0;
  int          n_err = 0;
  int          rel_cyc = 0;
  int          boot_cyc = 0;
  bit          booted = 1'b0;
  int          m_h = 1;
  logic [7:0]  m_p = 8'h00;
  logic        prev_csb = 1'b1;
  logic        prev_led0 = 1'b0;
  int          rise_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of the compare process: pad map, SPI idle rule, transfer
  // integrity at each deselect, reset values, and LED timing against the model.
  task automatic step();
    logic [7:0] led;
    logic [7:0] exp_led;
    @(negedge clock);
    led = mprj_io_out[9:2];
    check("pad_oeb", 64'(mprj_io_oeb), 64'(OEB_EXP));
    check("pad_out_unused", 64'(mprj_io_out & ~LED_MASK), 64'h0);
    if (flash_csb) check("sck_low_when_deselected", 64'(flash_clk), 64'h0);
    if (flash_csb && !prev_csb && !rst_at_edge) begin
      check("sck_rises_per_select", 64'(sck_rises), 64'd64);
      check("cmd_word", 64'(cmd_seen), 64'h0300_0000);
    end
    prev_csb = flash_csb;
    if (rst_at_edge) begin
      check("rst_csb", 64'(flash_csb), 64'd1);
      check("rst_sck", 64'(flash_clk), 64'd0);
      check("rst_io0", 64'(flash_io0), 64'd0);
      check("rst_led", 64'(led), 64'h0);
      check("rst_boot_done", 64'(boot_done), 64'd0);
      booted = 1'b0;
    end else if (!booted) begin
      check("led_before_boot", 64'(led), 64'h0);
      if (boot_done) begin
        booted   = 1'b1;
        boot_cyc = cyc;
        check("boot_latency_in_bound", 64'((cyc - rel_cyc) <= BOOT_MAX), 64'd1);
      end
    end else begin
      check("boot_done_held", 64'(boot_done), 64'd1);
      exp_led = ((((cyc - boot_cyc) / m_h) % 2) == 1) ? m_p : 8'h00;
      check("led_model", 64'(led), 64'(exp_led));
      if (led[0] && !prev_led0) rise_cyc.push_back(cyc);
    end
    prev_led0 = led[0];
  endtask

  // Load flash, derive expected blink parameters, pulse reset, release.
  task automatic boot(input logic [31:0] w);
    flash_word = w;
    if (w == 32'hFFFF_FFFF) begin
      m_h = 2000;
      m_p = 8'h01;
    end else begin
      m_h = (w[31:8] == 24'd0) ? 1 : int'(w[31:8]);
      m_p = w[7:0];
    end
    reset = 1'b1;
    rise_cyc.delete();
    repeat (3) step();
    reset   = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_boot();
    for (int i = 0; i < BOOT_MAX + 10 && !booted; i++) step();
    check("boot_reached", 64'(booted), 64'd1);
  endtask

  logic [7:0] a5_seq [6];

  initial begin
    a5_seq = '{8'h00, 8'hA5, 8'h00, 8'hA5, 8'h00, 8'hA5};

    // Half-period 0 promoted to 1: LED alternates every cycle.
    boot(32'h0000_00A5);
    wait_boot();
    for (int k = 0; k < 6; k++) begin
      check("a5_alternate", 64'(mprj_io_out[9:2]), 64'(a5_seq[k]));
      step();
    end

    // Abort at the 20th SCK rise, then reboot cleanly.
    boot(32'h0000_055A);
    for (int i = 0; i < 200 && sck_rises != 20; i++) step();
    check("reached_20_rises", 64'(sck_rises), 64'd20);
    reset = 1'b1;
    step();
    check("abort_csb_high", 64'(flash_csb), 64'd1);
    boot(32'h0000_055A);
    wait_boot();
    repeat (30) step();

    // Half-period 100, pattern 0x01.
    boot(32'h0000_6401);
    while (cyc - rel_cyc < 3500) step();
    check("rises_by_3500", 64'(rise_cyc.size() >= 8), 64'd1);
    if (rise_cyc.size() >= 8) begin
      check("first_rise_offset", 64'(rise_cyc[0] - boot_cyc), 64'd100);
      check("eighth_rise_span", 64'(rise_cyc[7] - rise_cyc[0]), 64'd1400);
    end

    // Erased flash: defaults 2000 / 0x01.
    boot(32'hFFFF_FFFF);
    while (rise_cyc.size() < 8 && (cyc - rel_cyc) < 75000) step();
    check("erased_8_rises", 64'(rise_cyc.size()), 64'd8);
    if (rise_cyc.size() == 8) begin
      check("erased_eighth_rise", 64'(rise_cyc[7] - boot_cyc), 64'd30000);
      check("erased_under_75000", 64'((rise_cyc[7] - rel_cyc) < 75000), 64'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
